// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage and IF/ID pipeline register of the
//                pipelined MIPS core. Owns the PC, drives the instruction
//                memory address, and captures the fetched word into IF/ID.
//                It takes the decoder's Branch/Jump outputs for the IF/ID
//                instruction, computes the redirect target, squashes the
//                wrong-path slot and reloads the PC.
//
//  Ports       : clk          - system clock, rising edge
//                rst          - synchronous active-high reset
//                stall        - hazard hold; freezes PC and IF/ID
//                imem_addr    - instruction memory byte address (= PC)
//                imem_data    - instruction word at imem_addr (same cycle)
//                id_branch    - decoder Branch for the IF/ID instruction
//                id_jump      - decoder Jump for the IF/ID instruction
//                id_cmp_eq    - ID-stage comparator result (rs == rt)
//                IR           - IF/ID instruction register
//                id_pc_plus4  - IF/ID copy of fetch PC + 4
//                id_valid     - IF/ID holds a real (non-squashed) instruction
//                fetch_count  - valid instructions written into IF/ID
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        id_branch,
    input  logic        id_jump,
    input  logic        id_cmp_eq,
    output logic [31:0] IR,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    // The PC is word aligned at all times; the reset value is forced aligned
    // so a misconfigured parameter cannot break that invariant.
    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_count;

    logic        w_take_jump;
    logic        w_take_branch;
    logic        w_redirect;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_target;
    logic [31:0] w_pc_next_seq;

    // Redirect decisions are gated by id_valid, so a squashed slot can never
    // redirect even if the decoder were to flag it. Jump has precedence over
    // branch should both ever be asserted together.
    assign w_take_jump   = r_valid & id_jump;
    assign w_take_branch = r_valid & id_branch & id_cmp_eq & ~id_jump;
    assign w_redirect    = w_take_jump | w_take_branch;

    // Targets have zero low bits by construction (offset and index are
    // shifted left by two, and id_pc_plus4 is aligned).
    assign w_branch_target = r_pc4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_jump_target   = {r_pc4[31:28], r_ir[25:0], 2'b00};
    assign w_target        = w_take_jump ? w_jump_target : w_branch_target;
    assign w_pc_next_seq   = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= c_reset_pc;
            r_ir    <= 32'h0000_0000;
            r_pc4   <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_count <= 32'h0000_0000;
        end else if (!stall) begin
            if (w_redirect) begin
                // No delay slot: the sequentially fetched word is dropped
                // and a bubble takes its place in IF/ID.
                r_pc    <= w_target;
                r_ir    <= 32'h0000_0000;
                r_pc4   <= 32'h0000_0000;
                r_valid <= 1'b0;
            end else begin
                r_pc    <= w_pc_next_seq;
                r_ir    <= imem_data;
                r_pc4   <= w_pc_next_seq;
                r_valid <= 1'b1;
                r_count <= r_count + 32'd1;
            end
        end
        // While stalled everything holds; a pending redirect is simply
        // re-evaluated on the first unstalled edge.
    end

    assign imem_addr   = r_pc;
    assign IR          = r_ir;
    assign id_pc_plus4 = r_pc4;
    assign id_valid    = r_valid;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A small instruction
//                memory and decoder surround the DUT; a reference model of
//                the IF/ID state pushes expected values into a queue at each
//                driven cycle, which are popped and compared after the edge.
//                Fixed-value checks cover the documented scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        id_branch;
    logic        id_jump;
    logic        id_cmp_eq;
    logic [31:0] IR;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count;

    int n_vec;
    int n_err;
    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_cnt;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .id_branch   (id_branch),
        .id_jump     (id_jump),
        .id_cmp_eq   (id_cmp_eq),
        .IR          (IR),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image. Unlisted addresses return a harmless addiu whose
    // immediate is the low half of the address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem_word = 32'h2008_0001;
            32'h0000_0004: imem_word = 32'h2009_0002;
            32'h0000_0008: imem_word = 32'h2000_0000;
            32'h0000_000C: imem_word = 32'h1109_0003; // beq -> 0x1C (taken)
            32'h0000_0020: imem_word = 32'h1109_0005; // beq not taken
            32'h0000_0024: imem_word = 32'h0800_0040; // j 0x100
            32'h0000_0104: imem_word = 32'h1109_0002; // beq -> 0x110 (taken)
            32'h0000_0114: imem_word = 32'h1109_FFB9; // beq -> 0xFFFFFFFC
            default:       imem_word = 32'h2400_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    assign imem_data = imem_word(imem_addr);

    // Decoder / comparator stand-ins: the beq at 0x20 is the only one whose
    // registers compare unequal.
    assign id_branch = (IR[31:26] == 6'h04);
    assign id_jump   = (IR[31:26] == 6'h02);
    assign id_cmp_eq = (IR != 32'h1109_0005);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Drive one cycle, predict its effect, then compare after the edge.
    task automatic step(input logic r, input logic s);
        exp_t e;
        logic tj;
        logic tk;
        logic [31:0] tgt;
        rst   = r;
        stall = s;
        tj  = m_valid && (m_ir[31:26] == 6'h02);
        tk  = m_valid && (m_ir[31:26] == 6'h04) && (m_ir != 32'h1109_0005) && !tj;
        tgt = tj ? {m_pc4[31:28], m_ir[25:0], 2'b00}
                 : m_pc4 + {{14{m_ir[15]}}, m_ir[15:0], 2'b00};
        if (r) begin
            m_pc = 32'h0; m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
        end else if (s) begin
            // hold
        end else if (tj || tk) begin
            m_pc = tgt; m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            m_ir    = imem_word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
        e.pc = m_pc; e.ir = m_ir; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pc",    imem_addr,             e.pc);
        check("ir",    IR,                    e.ir);
        check("pc4",   id_pc_plus4,           e.pc4);
        check("valid", {31'h0, id_valid},     {31'h0, e.valid});
        check("count", fetch_count,           e.cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; stall = 1'b0;
        m_pc = 32'h0; m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;

        // Reset for two edges
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_ir",    IR,          32'h0);
        check("rst_valid", {31'h0, id_valid}, 32'h0);
        check("rst_pc",    imem_addr,   32'h0);

        // Sequential fetch
        step(1'b0, 1'b0);
        check("seq1_ir",  IR,          32'h2008_0001);
        check("seq1_pc4", id_pc_plus4, 32'h4);
        step(1'b0, 1'b0);
        check("seq2_ir",  IR,          32'h2009_0002);
        check("seq2_pc4", id_pc_plus4, 32'h8);
        check("seq2_cnt", fetch_count, 32'd2);

        // Taken beq at 0xC
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("beq_in_ir", IR, 32'h1109_0003);
        step(1'b0, 1'b0);
        check("beq_pc",    imem_addr,         32'h1C);
        check("beq_ir0",   IR,                32'h0);
        check("beq_bub",   {31'h0, id_valid}, 32'h0);
        step(1'b0, 1'b0);
        check("beq_tgt",   IR,                32'h2400_001C);

        // Not-taken beq at 0x20, then jump at 0x24
        step(1'b0, 1'b0);
        check("nt_in_ir",  IR, 32'h1109_0005);
        step(1'b0, 1'b0);
        check("nt_pc",     imem_addr,         32'h28);
        check("nt_valid",  {31'h0, id_valid}, 32'h1);
        step(1'b0, 1'b0);
        check("j_pc",      imem_addr,         32'h100);
        check("j_bub",     {31'h0, id_valid}, 32'h0);

        // Taken beq at 0x104 held by a 3-edge stall
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("st_in_ir",  IR, 32'h1109_0002);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check("st_pc",  imem_addr,   32'h108);
            check("st_ir",  IR,          32'h1109_0002);
            check("st_cnt", fetch_count, 32'd9);
        end
        step(1'b0, 1'b0);
        check("st_redir", imem_addr, 32'h110);

        // Backward branch that lands on 0xFFFFFFFC, then wraps to 0
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("wrap_pc",  imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0);
        check("wrap_pc0", imem_addr,   32'h0);
        check("wrap_p4",  id_pc_plus4, 32'h0);
        check("wrap_ir",  IR,          32'h2400_FFFC);

        // Run back to the beq at 0xC and reset on its redirect edge
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("rr_in_ir", IR, 32'h1109_0003);
        step(1'b1, 1'b0);
        check("rr_pc",    imem_addr,         32'h0);
        check("rr_valid", {31'h0, id_valid}, 32'h0);
        check("rr_cnt",   fetch_count,       32'h0);
        step(1'b0, 1'b0);
        check("rr_fetch", IR, 32'h2008_0001);
        step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
